gb_cart_loader: RTL and testbench



---
 rtl/gb_cart_pkg.sv | 30 +++
 rtl/gb_hdr_checksum.sv | 58 +++++
 rtl/gb_cart_loader.sv | 131 +++++++++++++
 tb/tb_gb_cart_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cart_pkg.sv
// -----------------------------------------------------------------------------
// gb_cart_pkg
// Shared definitions for the Game Boy cartridge download path:
//   - cartridge header byte offsets used for capture and checksum,
//   - loader state encoding,
//   - rom_mask_f: ROM size code -> bank mask (also used by the MBC mapper).
// -----------------------------------------------------------------------------
package gb_cart_pkg;

   // Header byte addresses (ROM image byte offsets, word aligned)
   localparam int unsigned HDR_TYPE     = 32'h146;  // word 0x146: hi byte = 0x147 (MBC type)
   localparam int unsigned HDR_SIZE     = 32'h148;  // word 0x148: lo = ROM size, hi = RAM size
   localparam int unsigned HDR_CK_FIRST = 32'h134;  // first word summed by the checksum
   localparam int unsigned HDR_CK_LAST  = 32'h14C;  // lo = 0x14C, hi = stored checksum 0x14D

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLOT  = 2'd1,
      ST_WRITE = 2'd2
   } cart_state_t;

   // ROM size code n selects 2^(n+1) banks; codes above 6 saturate at 128 banks.
   function automatic logic [6:0] rom_mask_f(input logic [7:0] n);
      logic [7:0] m;
      if (n > 8'd6) return 7'h7F;
      m = (8'd2 << n[2:0]) - 8'd1;
      return m[6:0];
   endfunction

endpackage

// File: rtl/gb_hdr_checksum.sv
// -----------------------------------------------------------------------------
// gb_hdr_checksum
// Running Game Boy header checksum over bytes 0x134..0x14C, compared against the
// stored byte at 0x14D. Fed one accepted 16-bit word at a time.
//   clk_sys, reset_n : clock / async active-low reset
//   clr              : restart (download start); takes effect before a same-cycle stb
//   stb              : accepted word strobe
//   addr, data       : byte address (even) and word (lo = even byte)
//   hdr_ok           : checksum matched, valid after word 0x14C
// -----------------------------------------------------------------------------
module gb_hdr_checksum
   import gb_cart_pkg::*;
#(
   parameter int AW = 25
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          stb,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   data,
   output logic          hdr_ok
);

   logic [7:0] x;
   logic [7:0] x_base;
   logic [7:0] x_run;
   logic [7:0] x_fin;
   logic       in_run;
   logic       is_last;

   // A clear in the same cycle as a word means that word starts from zero.
   assign x_base  = clr ? 8'h00 : x;
   // Each header byte contributes -(byte + 1); two bytes per word.
   assign x_run   = x_base - data[7:0] - data[15:8] - 8'd2;
   assign x_fin   = x_base - data[7:0] - 8'd1;
   assign in_run  = (addr >= AW'(HDR_CK_FIRST)) && (addr <= AW'(HDR_CK_LAST - 2));
   assign is_last = (addr == AW'(HDR_CK_LAST));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         x      <= 8'h00;
         hdr_ok <= 1'b0;
      end else begin
         if (clr) begin
            x      <= 8'h00;
            hdr_ok <= 1'b0;
         end
         if (stb && in_run) begin
            x <= x_run;
         end else if (stb && is_last) begin
            x      <= x_fin;
            hdr_ok <= (x_fin == data[15:8]);
         end
      end
   end

endmodule

// File: rtl/gb_cart_loader.sv
// -----------------------------------------------------------------------------
// gb_cart_loader
// Accepts ROM words from the HPS ioctl port, writes each into SDRAM in a
// ce_cpu slot (throttling the HPS via ioctl_wait), captures the cartridge
// header, derives bank masks and checks the header checksum.
//   clk_sys, reset_n      : clock / async active-low reset
//   ce_cpu                : SDRAM slot strobe (1 in 8)
//   ioctl_download/wr/addr/dout : HPS download stream (addr is a byte address)
//   ioctl_wait            : stall while a word is pending
//   dn_addr/dn_data/dn_we : SDRAM write port (word address), we held one slot
//   cart_ready            : image complete, header fields valid
//   cart_mbc_type/rom_size/ram_size : header bytes 0x147/0x148/0x149
//   rom_mask, ram_mask    : bank masks from the size fields
//   hdr_ok                : header checksum matched
// -----------------------------------------------------------------------------
module gb_cart_loader
   import gb_cart_pkg::*;
#(
   parameter int AW = 25
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ce_cpu,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [AW-1:0] ioctl_addr,
   input  logic [15:0]   ioctl_dout,
   output logic          ioctl_wait,
   output logic [AW-2:0] dn_addr,
   output logic [15:0]   dn_data,
   output logic          dn_we,
   output logic          cart_ready,
   output logic [7:0]    cart_mbc_type,
   output logic [7:0]    cart_rom_size,
   output logic [7:0]    cart_ram_size,
   output logic [6:0]    rom_mask,
   output logic [1:0]    ram_mask,
   output logic          hdr_ok
);

   cart_state_t   state;
   logic          dl_q;
   logic [AW-2:0] word_cnt;
   logic          dl_rise;
   logic          accept;
   logic          done_wr;

   assign dl_rise = ioctl_download && !dl_q;
   // Words arriving outside IDLE or outside a download window are dropped.
   assign accept  = (state == ST_IDLE) && ioctl_wr && ioctl_download;
   assign done_wr = (state == ST_WRITE) && ce_cpu;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         dl_q          <= 1'b0;
         word_cnt      <= '0;
         ioctl_wait    <= 1'b0;
         dn_addr       <= '0;
         dn_data       <= 16'h0000;
         dn_we         <= 1'b0;
         cart_ready    <= 1'b0;
         cart_mbc_type <= 8'h00;
         cart_rom_size <= 8'h00;
         cart_ram_size <= 8'h00;
      end else begin
         dl_q <= ioctl_download;

         // Restart clears first; a word accepted this same cycle still counts.
         word_cnt <= (dl_rise ? '0 : word_cnt) + (AW-1)'(done_wr);

         if (dl_rise) begin
            cart_ready    <= 1'b0;
            cart_mbc_type <= 8'h00;
            cart_rom_size <= 8'h00;
            cart_ram_size <= 8'h00;
         end else if (!ioctl_download && state == ST_IDLE && word_cnt != '0) begin
            cart_ready <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  dn_addr    <= ioctl_addr[AW-1:1];
                  dn_data    <= ioctl_dout;
                  ioctl_wait <= 1'b1;
                  state      <= ST_SLOT;
                  // Placed after the restart clear so capture wins on a tie.
                  if (ioctl_addr == AW'(HDR_TYPE)) begin
                     cart_mbc_type <= ioctl_dout[15:8];
                  end
                  if (ioctl_addr == AW'(HDR_SIZE)) begin
                     cart_rom_size <= ioctl_dout[7:0];
                     cart_ram_size <= ioctl_dout[15:8];
                  end
               end
            end
            // A ce_cpu coinciding with acceptance was seen in IDLE, so the
            // write waits for the following strobe.
            ST_SLOT: begin
               if (ce_cpu) begin
                  dn_we <= 1'b1;
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (ce_cpu) begin
                  dn_we      <= 1'b0;
                  ioctl_wait <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rom_mask = rom_mask_f(cart_rom_size);
   assign ram_mask = (cart_ram_size == 8'h03) ? 2'b11 : 2'b00;

   gb_hdr_checksum #(.AW(AW)) u_ck (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr     (dl_rise),
      .stb     (accept),
      .addr    (ioctl_addr),
      .data    (ioctl_dout),
      .hdr_ok  (hdr_ok)
   );

endmodule

// File: tb/tb_gb_cart_loader.sv
// -----------------------------------------------------------------------------
// tb_gb_cart_loader: directed bench for gb_cart_loader.
// ce_cpu is a free-running 1-in-8 strobe; stimulus and sampling happen on the
// falling edge of clk_sys.
// -----------------------------------------------------------------------------
module tb_gb_cart_loader;
   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce_cpu;
   logic          ioctl_download = 1'b0;
   logic          ioctl_wr = 1'b0;
   logic [AW-1:0] ioctl_addr = '0;
   logic [15:0]   ioctl_dout = 16'h0000;
   logic          ioctl_wait;
   logic [AW-2:0] dn_addr;
   logic [15:0]   dn_data;
   logic          dn_we;
   logic          cart_ready;
   logic [7:0]    cart_mbc_type, cart_rom_size, cart_ram_size;
   logic [6:0]    rom_mask;
   logic [1:0]    ram_mask;
   logic          hdr_ok;

   int total = 0;
   int bad   = 0;

   logic [2:0] ce_ph = 3'd0;
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) ce_ph <= ce_ph + 3'd1;
   assign ce_cpu = (ce_ph == 3'd7);

   gb_cart_loader #(.AW(AW)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ce_cpu         (ce_cpu),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_we          (dn_we),
      .cart_ready     (cart_ready),
      .cart_mbc_type  (cart_mbc_type),
      .cart_rom_size  (cart_rom_size),
      .cart_ram_size  (cart_ram_size),
      .rom_mask       (rom_mask),
      .ram_mask       (ram_mask),
      .hdr_ok         (hdr_ok)
   );

   // Record address/data at every dn_we rising edge.
   logic [AW-2:0] rec_addr [0:511];
   logic [15:0]   rec_data [0:511];
   int            n_pulse = 0;
   logic          we_q = 1'b0;
   always @(negedge clk_sys) begin
      if (dn_we && !we_q && n_pulse < 512) begin
         rec_addr[n_pulse] <= dn_addr;
         rec_data[n_pulse] <= dn_data;
         n_pulse           <= n_pulse + 1;
      end
      we_q <= dn_we;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Send one word at a falling edge and hold off until ioctl_wait drops.
   // lat = cycles ioctl_wait was high, we_cyc = cycles dn_we was high.
   task automatic send_word(input logic [AW-1:0] a, input logic [15:0] d, input bit stray,
                            output int lat, output int we_cyc, output logic w1);
      bit s;
      s = stray;
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      w1 = ioctl_wait;
      if (s) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'h1FE; ioctl_dout = 16'hDEAD;
      end
      lat = 0; we_cyc = 0;
      while (ioctl_wait && lat < 40) begin
         lat++;
         if (dn_we) we_cyc++;
         @(negedge clk_sys);
         if (s) begin ioctl_wr = 1'b0; s = 0; end
      end
   endtask

   task automatic restart_dl();
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   // Header words 0x134..0x14C: w134 first, zeros between, w14c last.
   task automatic send_image(input logic [15:0] w134, input logic [15:0] w14c);
      int l, w;
      logic v;
      for (int a = 'h134; a <= 'h14C; a += 2) begin
         send_word(AW'(a), (a == 'h134) ? w134 : (a == 'h14C) ? w14c : 16'h0000, 1'b0, l, w, v);
      end
   endtask

   initial begin
      int   lat, we_cyc, base, n, early;
      logic w1;

      // Reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);
      chk("rst_we", 32'(dn_we), 32'd0);
      chk("rst_ready", 32'(cart_ready), 32'd0);
      chk("rst_rom_mask", 32'(rom_mask), 32'h01);
      chk("rst_ram_mask", 32'(ram_mask), 32'd0);
      chk("rst_hdr_ok", 32'(hdr_ok), 32'd0);
      chk("rst_dn_data", 32'(dn_data), 32'd0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Single word
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      send_word(25'h0, 16'hC3AF, 1'b0, lat, we_cyc, w1);
      chk("single_wait_next", 32'(w1), 32'd1);
      chk("single_lat_range", 32'(lat >= 9 && lat <= 16), 32'd1);
      chk("single_we_cyc", 32'(we_cyc), 32'd8);
      chk("single_dn_addr", 32'(dn_addr), 32'd0);
      chk("single_dn_data", 32'(dn_data), 32'hC3AF);
      chk("single_not_ready", 32'(cart_ready), 32'd0);

      // Header capture, then end of download
      send_word(25'h146, 16'h0300, 1'b0, lat, we_cyc, w1);
      send_word(25'h148, 16'h0305, 1'b0, lat, we_cyc, w1);
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("hdr_mbc", 32'(cart_mbc_type), 32'h03);
      chk("hdr_rom_size", 32'(cart_rom_size), 32'h05);
      chk("hdr_ram_size", 32'(cart_ram_size), 32'h03);
      chk("hdr_rom_mask", 32'(rom_mask), 32'h3F);
      chk("hdr_ram_mask", 32'(ram_mask), 32'h3);
      chk("hdr_ready", 32'(cart_ready), 32'd1);

      // Second download clears ready and fields on its rising edge
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      chk("redl_ready", 32'(cart_ready), 32'd0);
      chk("redl_mbc", 32'(cart_mbc_type), 32'h00);
      chk("redl_rom_mask", 32'(rom_mask), 32'h01);
      chk("redl_ram_mask", 32'(ram_mask), 32'h0);

      // Checksum: 0x134=01,0x135=02, rest 0, 0x14C=0x10 -> expected 0xD4
      send_image(16'h0201, 16'hD410);
      chk("ck_mixed_ok", 32'(hdr_ok), 32'd1);
      restart_dl();
      chk("ck_clear_on_dl", 32'(hdr_ok), 32'd0);
      send_image(16'h0000, 16'hE700);
      chk("ck_zero_e7", 32'(hdr_ok), 32'd1);
      restart_dl();
      send_image(16'h0000, 16'hE600);
      chk("ck_zero_e6", 32'(hdr_ok), 32'd0);

      // 256-word burst, stray ioctl_wr injected during word 100's SLOT
      restart_dl();
      base = n_pulse;
      for (int i = 0; i < 256; i++) begin
         send_word(AW'(2 * i), {8'(i), ~8'(i)}, (i == 100), lat, we_cyc, w1);
      end
      @(negedge clk_sys);
      chk("burst_pulses", 32'(n_pulse - base), 32'd256);
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("burst_addr%0d", i), 32'(rec_addr[base + i]), 32'(i));
         chk($sformatf("burst_data%0d", i), 32'(rec_data[base + i]), 32'({8'(i), ~8'(i)}));
      end

      // Download falls while in SLOT; acceptance aligned with a ce_cpu strobe
      n = 0;
      while (!ce_cpu && n < 16) begin @(negedge clk_sys); n++; end
      ioctl_addr = 25'h400; ioctl_dout = 16'h1111; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      lat = 0; we_cyc = 0; early = 0;
      while (ioctl_wait && lat < 40) begin
         lat++;
         if (dn_we) we_cyc++;
         if (cart_ready) early = 1;
         @(negedge clk_sys);
      end
      chk("slotdrop_lat", 32'(lat), 32'd16);
      chk("slotdrop_we_cyc", 32'(we_cyc), 32'd8);
      chk("slotdrop_early_ready", 32'(early), 32'd0);
      chk("slotdrop_ready_idle", 32'(cart_ready), 32'd0);
      @(negedge clk_sys);
      chk("slotdrop_ready", 32'(cart_ready), 32'd1);

      // ioctl_wr with download low is ignored
      ioctl_addr = 25'h10; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("nodl_wait", 32'(ioctl_wait), 32'd0);

      // Word coincident with download rising edge: cleared then captured
      ioctl_download = 1'b1; ioctl_addr = 25'h148; ioctl_dout = 16'h0102; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("tie_wait", 32'(ioctl_wait), 32'd1);
      chk("tie_ready", 32'(cart_ready), 32'd0);
      chk("tie_rom_size", 32'(cart_rom_size), 32'h02);
      chk("tie_ram_size", 32'(cart_ram_size), 32'h01);
      chk("tie_rom_mask", 32'(rom_mask), 32'h07);
      n = 0;
      while (ioctl_wait && n < 40) begin @(negedge clk_sys); n++; end
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("tie_counted_ready", 32'(cart_ready), 32'd1);

      // Reset pulsed during WRITE
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      ioctl_addr = 25'h20; ioctl_dout = 16'h5555; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      n = 0;
      while (!dn_we && n < 20) begin @(negedge clk_sys); n++; end
      chk("rstw_in_write", 32'(dn_we), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstw_we", 32'(dn_we), 32'd0);
      chk("rstw_wait", 32'(ioctl_wait), 32'd0);
      chk("rstw_rom_mask", 32'(rom_mask), 32'h01);
      @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      send_word(25'h30, 16'hBEEF, 1'b0, lat, we_cyc, w1);
      chk("rstw_idle_accept", 32'(w1), 32'd1);
      chk("rstw_lat_range", 32'(lat >= 9 && lat <= 16), 32'd1);
      chk("rstw_dn_data", 32'(dn_data), 32'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
